// File: rtl/deaggregator.sv
// Splits wide words of up to FETCH_WIDTH lanes into a stream of DATA_WIDTH words.
// A two-entry buffer decouples the wide-word sender from the serial receiver.
module deaggregator #(
    parameter int DATA_WIDTH  = 8,
    parameter int FETCH_WIDTH = 6
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [FETCH_WIDTH*DATA_WIDTH-1:0]    sender_data,
    input  logic                                 sender_enq,
    output logic                                 sender_full_n,
    output logic [DATA_WIDTH-1:0]                receiver_data,
    input  logic                                 receiver_full_n,
    output logic                                 receiver_enq,
    input  logic                                 change_fetch_width,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0]     input_fetch_width
);

    localparam int IW = $clog2(FETCH_WIDTH + 1);
    localparam int WW = FETCH_WIDTH * DATA_WIDTH;

    logic [WW-1:0]         buf_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            count_q, count_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [IW-1:0]         active_q, active_d;
    logic [IW-1:0]         pend_w_q, pend_w_d;
    logic                  pend_q, pend_d;
    logic [IW-1:0]         req_w;
    logic                  do_wr, release_w;
    logic [DATA_WIDTH-1:0] lanes [FETCH_WIDTH];

    assign sender_full_n = (count_q != 2'd2);
    assign receiver_enq  = (count_q != 2'd0) && receiver_full_n;
    assign do_wr         = sender_enq && sender_full_n;
    assign release_w     = receiver_enq && (idx_q == active_q - IW'(1));

    genvar gi;
    generate
        for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_lane
            assign lanes[gi] = buf_q[rd_ptr_q][gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    always_comb begin
        receiver_data = '0;
        if (idx_q < IW'(FETCH_WIDTH)) begin
            receiver_data = lanes[idx_q];
        end
    end

    // Requested width clamped into 1..FETCH_WIDTH.
    always_comb begin
        req_w = input_fetch_width;
        if (input_fetch_width == '0) begin
            req_w = IW'(1);
        end else if (input_fetch_width > IW'(FETCH_WIDTH)) begin
            req_w = IW'(FETCH_WIDTH);
        end
    end

    always_comb begin
        idx_d    = idx_q;
        count_d  = count_q;
        active_d = active_q;
        pend_w_d = pend_w_q;
        pend_d   = pend_q;

        if (receiver_enq) begin
            idx_d = release_w ? '0 : idx_q + IW'(1);
        end

        case ({do_wr, release_w})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // Switch widths only on a word boundary so a word in flight keeps its width.
        if (pend_q && (idx_d == '0)) begin
            active_d = pend_w_q;
            pend_d   = 1'b0;
        end
        if (change_fetch_width) begin
            pend_w_d = req_w;
            pend_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else if (do_wr) begin
            buf_q[wr_ptr_q] <= sender_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            idx_q    <= '0;
            active_q <= IW'(FETCH_WIDTH);
            pend_w_q <= IW'(FETCH_WIDTH);
            pend_q   <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (release_w) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q  <= count_d;
            idx_q    <= idx_d;
            active_q <= active_d;
            pend_w_q <= pend_w_d;
            pend_q   <= pend_d;
        end
    end

endmodule
